dcache_refill: RTL and testbench

DCACHE_REFILL -- requirements
Module: dcache_refill

---
 rtl/dcache_refill_if.sv | 30 +++
 rtl/dcache_refill.sv | 146 ++++++++++++++
 tb/tb_dcache_refill.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_refill_if.sv
// AXI4 read-address / read-data channel bundle used by the D-cache refill engine.
// master: the refill engine (issues AR, accepts R); slave: the memory side.
interface dcache_refill_if;
  // Read address channel
  logic         arvalid;
  logic [63:0]  araddr;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arready;

  // Read data channel
  logic         rvalid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic [3:0]   rid;
  logic         rready;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/dcache_refill.sv
// D-cache line refill engine: on a controller request, issues one 4-beat
// 128-bit INCR AXI read burst for the line, streams each beat into the data
// array, and reports completion with a sticky error status.
module dcache_refill #(
  parameter logic [3:0] AXI_ID = 4'b0001
) (
  input  logic          clock,
  input  logic          reset,

  input  logic          ctrl2refill_valid,
  input  logic [5:0]    ctrl2refill_index,
  input  logic [2:0]    ctrl2refill_way,
  input  logic [43:0]   ctrl2refill_tag,

  output logic          refill2ctrl_ready,
  output logic          refill2ctrl_error,

  output logic          refill2data_array_valid,
  output logic [5:0]    refill2data_array_index,
  output logic [2:0]    refill2data_array_way,
  output logic [1:0]    refill2data_array_offset,
  output logic [127:0]  refill2data_array_wdata,

  dcache_refill_if.master axi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_q;
  logic [5:0]   index_q;
  logic [2:0]   way_q;
  logic [43:0]  tag_q;
  logic [1:0]   beat_q;
  logic         err_q;
  logic         arvalid_q;
  logic         rready_q;
  logic         ready_q;

  logic         beat_acc;
  logic         beat_bad;
  logic         beat_end;
  logic [1:0]   beat_d;
  logic         err_d;

  // Per-beat qualification: acceptance, protocol/response errors, burst end.
  always_comb begin
    beat_acc = rready_q & axi.rvalid;
    // rresp[1] set means SLVERR/DECERR; rlast must appear on beat 3 only.
    beat_bad = axi.rresp[1]
             | (axi.rid != AXI_ID)
             | (axi.rlast != (beat_q == 2'd3));
    beat_end = axi.rlast | (beat_q == 2'd3);
    beat_d   = beat_q + 2'd1;
    err_d    = err_q | (beat_acc & beat_bad);
  end

  // Refill sequencer with registered handshake outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      index_q   <= '0;
      way_q     <= '0;
      tag_q     <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctrl2refill_valid) begin
            index_q   <= ctrl2refill_index;
            way_q     <= ctrl2refill_way;
            tag_q     <= ctrl2refill_tag;
            beat_q    <= '0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (beat_acc) begin
            beat_q <= beat_d;
            err_q  <= err_d;
            if (beat_end) begin
              rready_q <= 1'b0;
              ready_q  <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          ready_q   <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Read-address channel: built only from captured state, so it is stable
  // for as long as arvalid is held.
  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = {8'h00, tag_q, index_q, 6'h00};
  assign axi.arid    = AXI_ID;
  assign axi.arlen   = 8'd3;
  assign axi.arsize  = 3'b100;
  assign axi.arburst = 2'b01;
  assign axi.rready  = rready_q;

  // Completion status is only presented alongside the ready pulse.
  assign refill2ctrl_ready = ready_q;
  assign refill2ctrl_error = ready_q & err_q;

  // Data-array write path: same-cycle write for every accepted beat.
  assign refill2data_array_valid  = beat_acc;
  assign refill2data_array_index  = index_q;
  assign refill2data_array_way    = way_q;
  assign refill2data_array_offset = beat_q;
  assign refill2data_array_wdata  = axi.rdata;

  a_ar_stable: assert property (@(posedge clock) disable iff (!reset)
    (axi.arvalid && !axi.arready) |=> (axi.arvalid && $stable(axi.araddr)));

  a_ch_exclusive: assert property (@(posedge clock) disable iff (!reset)
    !(axi.arvalid && axi.rready) && !(refill2ctrl_ready && (axi.arvalid || axi.rready)));

endmodule

// File: tb/tb_dcache_refill.sv
// Scoreboard bench for dcache_refill: expected data-array writes and
// completion statuses are queued as stimulus is driven and retired by a
// negedge monitor as the DUT produces them.
module tb_dcache_refill;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ctrl_valid;
  logic [5:0]    ctrl_index;
  logic [2:0]    ctrl_way;
  logic [43:0]   ctrl_tag;
  logic          ready;
  logic          error;
  logic          dv;
  logic [5:0]    d_index;
  logic [2:0]    d_way;
  logic [1:0]    d_offset;
  logic [127:0]  d_wdata;

  dcache_refill_if axi_if();

  dcache_refill #(.AXI_ID(4'b0001)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .ctrl2refill_valid        (ctrl_valid),
    .ctrl2refill_index        (ctrl_index),
    .ctrl2refill_way          (ctrl_way),
    .ctrl2refill_tag          (ctrl_tag),
    .refill2ctrl_ready        (ready),
    .refill2ctrl_error        (error),
    .refill2data_array_valid  (dv),
    .refill2data_array_index  (d_index),
    .refill2data_array_way    (d_way),
    .refill2data_array_offset (d_offset),
    .refill2data_array_wdata  (d_wdata),
    .axi                      (axi_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   off;
    logic [5:0]   idx;
    logic [2:0]   way;
    logic [127:0] data;
  } wr_t;

  wr_t  wq[$];
  logic eq[$];
  wr_t  mon_w;
  logic mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Retire data-array writes and completion pulses against the scoreboard.
  always @(negedge clock) begin
    if (dv) begin
      if (wq.size() == 0) check("unexp_write", dv, 1'b0);
      else begin
        mon_w = wq.pop_front();
        check("wr_offset", d_offset, mon_w.off);
        check("wr_index",  d_index,  mon_w.idx);
        check("wr_way",    d_way,    mon_w.way);
        check("wr_data",   d_wdata,  mon_w.data);
      end
    end
    if (ready) begin
      if (eq.size() == 0) check("unexp_ready", ready, 1'b0);
      else begin
        mon_e = eq.pop_front();
        check("done_error", error, mon_e);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, axi_if.arvalid, 1'b0);
    check({tag, "_rready"},  axi_if.rready,  1'b0);
    check({tag, "_ready"},   ready,          1'b0);
    check({tag, "_error"},   error,          1'b0);
    check({tag, "_dv"},      dv,             1'b0);
    check({tag, "_araddr"},  axi_if.araddr,  64'h0);
    check({tag, "_arid"},    axi_if.arid,    4'h1);
    check({tag, "_arlen"},   axi_if.arlen,   8'd3);
    check({tag, "_arsize"},  axi_if.arsize,  3'b100);
    check({tag, "_arburst"}, axi_if.arburst, 2'b01);
    check({tag, "_d_off"},   d_offset,       2'd0);
  endtask

  // One refill transaction. Negative beat numbers disable the matching fault.
  task automatic refill(input logic [5:0] idx, input logic [2:0] wy, input logic [43:0] tg,
                        input int ar_delay, input bit toggle,
                        input int bad_resp_beat, input int bad_id_beat,
                        input int early_last, input bit no_last,
                        input int reset_beat, input bit junk_r);
    logic [63:0]  exp_addr;
    logic [127:0] d;
    int           nb;
    int           beat;
    int           n;
    bit           gap;
    bit           exp_err;
    wr_t          w;

    exp_addr = {8'h00, tg, idx, 6'h00};
    nb       = (early_last >= 0) ? early_last + 1 : 4;
    exp_err  = 1'b0;

    ctrl_valid = 1'b1;
    ctrl_index = idx;
    ctrl_way   = wy;
    ctrl_tag   = tg;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = junk_r;
    axi_if.rdata   = {$urandom, $urandom, $urandom, $urandom};
    axi_if.rresp   = 2'b00;
    axi_if.rid     = 4'h1;
    axi_if.rlast   = junk_r;

    tick();
    n = 0;
    while (!axi_if.arvalid && n < 8) begin
      tick();
      n++;
    end
    check("arvalid_latency", n, 0);
    check("arvalid",  axi_if.arvalid, 1'b1);
    check("araddr",   axi_if.araddr,  exp_addr);
    check("arid",     axi_if.arid,    4'h1);
    check("arlen",    axi_if.arlen,   8'd3);
    check("arsize",   axi_if.arsize,  3'b100);
    check("arburst",  axi_if.arburst, 2'b01);
    check("rready_in_addr", axi_if.rready, 1'b0);

    for (int i = 0; i < ar_delay; i++) begin
      tick();
      check("arvalid_hold",  axi_if.arvalid, 1'b1);
      check("araddr_stable", axi_if.araddr,  exp_addr);
    end
    axi_if.arready = 1'b1;
    tick();
    axi_if.arready = 1'b0;
    check("arvalid_drop", axi_if.arvalid, 1'b0);
    check("rready_rise",  axi_if.rready,  1'b1);

    beat = 0;
    gap  = 1'b0;
    while (beat < nb) begin
      if (gap) begin
        axi_if.rvalid = 1'b0;
        axi_if.rdata  = {$urandom, $urandom, $urandom, $urandom};
        gap = 1'b0;
      end else begin
        d = {$urandom, $urandom, $urandom, $urandom};
        axi_if.rdata  = d;
        axi_if.rresp  = (beat == bad_resp_beat) ? 2'b10 : 2'b00;
        axi_if.rid    = (beat == bad_id_beat) ? 4'h5 : 4'h1;
        axi_if.rlast  = (beat == early_last) || (beat == 3 && !no_last);
        axi_if.rvalid = 1'b1;
        if (beat == reset_beat) begin
          #1 reset = 1'b0;
          #1 check_reset_outputs("rst_mid");
          axi_if.rvalid = 1'b0;
          axi_if.rlast  = 1'b0;
          ctrl_valid    = 1'b0;
          tick();
          check("rst_no_ready", ready, 1'b0);
          tick();
          check("rst_state_idle", axi_if.arvalid | axi_if.rready | ready, 1'b0);
          reset = 1'b1;
          tick();
          check("rst_wq_drained", wq.size(), 0);
          return;
        end
        if ((beat == bad_resp_beat) || (beat == bad_id_beat) ||
            (beat == early_last && beat < 3) || (beat == 3 && no_last))
          exp_err = 1'b1;
        w.off  = beat[1:0];
        w.idx  = idx;
        w.way  = wy;
        w.data = d;
        wq.push_back(w);
        beat++;
        gap = toggle;
      end
      tick();
    end
    axi_if.rvalid = 1'b0;
    axi_if.rlast  = 1'b0;
    axi_if.rresp  = 2'b00;
    axi_if.rid    = 4'h1;

    eq.push_back(exp_err);
    check("ready_after_last_beat", ready, 1'b1);
    check("rready_drop", axi_if.rready, 1'b0);
    n = 0;
    while (!ready && n < 8) begin
      tick();
      n++;
    end
    ctrl_valid = 1'b0;
    tick();
    check("ready_one_cycle", ready, 1'b0);
    check("wq_drained", wq.size(), 0);
    check("eq_drained", eq.size(), 0);
    check("idle_arvalid", axi_if.arvalid, 1'b0);
  endtask

  initial begin
    ctrl_valid = 1'b0;
    ctrl_index = '0;
    ctrl_way   = '0;
    ctrl_tag   = '0;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rdata   = '0;
    axi_if.rresp   = 2'b00;
    axi_if.rlast   = 1'b0;
    axi_if.rid     = 4'h1;

    #2 check_reset_outputs("rst_init");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Stray beats while idle must never reach the data array.
    axi_if.rvalid = 1'b1;
    axi_if.rlast  = 1'b1;
    tick();
    tick();
    check("idle_rready", axi_if.rready, 1'b0);
    axi_if.rvalid = 1'b0;
    axi_if.rlast  = 1'b0;
    tick();

    // Nominal refill
    refill(6'h2A, 3'd3, 44'h123, 0, 1'b0, -1, -1, -1, 1'b0, -1, 1'b0);
    // Backpressure on AR and toggling rvalid, with stray beats during ADDR
    refill(6'h15, 3'd5, 44'hABC_DEF0_1234, 3, 1'b1, -1, -1, -1, 1'b0, -1, 1'b1);
    // Bad response on beat 1, then a clean refill
    refill(6'h01, 3'd1, 44'h0000_0000_777, 0, 1'b0, 1, -1, -1, 1'b0, -1, 1'b0);
    refill(6'h3F, 3'd7, 44'hFFF_FFFF_FFFF, 0, 1'b0, -1, -1, -1, 1'b0, -1, 1'b0);
    // Early rlast on beat 1
    refill(6'h10, 3'd2, 44'h0AB_CDEF_0123, 0, 1'b0, -1, -1, 1, 1'b0, -1, 1'b0);
    // Missing rlast on beat 3
    refill(6'h20, 3'd4, 44'h000_0000_0001, 1, 1'b0, -1, -1, -1, 1'b1, -1, 1'b0);
    // Wrong rid on beat 0
    refill(6'h05, 3'd0, 44'h555_5555_5555, 0, 1'b0, -1, 0, -1, 1'b0, -1, 1'b0);
    // Async reset during beat 2, then a normal refill
    refill(6'h2A, 3'd6, 44'h876_5432_10FE, 0, 1'b0, -1, -1, -1, 1'b0, 2, 1'b0);
    refill(6'h0C, 3'd1, 44'h246_8ACE_1357, 0, 1'b0, -1, -1, -1, 1'b0, -1, 1'b0);
    // A few random clean refills
    for (int k = 0; k < 4; k++)
      refill(6'($urandom), 3'($urandom), {12'($urandom), 32'($urandom)},
             int'($urandom_range(0, 2)), 1'($urandom), -1, -1, -1, 1'b0, -1, 1'($urandom));

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
